// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS core front end.
package cpu_pkg;

  typedef enum logic [2:0] {
    RST,
    FETCH,
    EXEC,
    HALT,
    FAULT
  } pc_state_t;

  localparam int WORD_BYTES = 4;
  localparam int PC_W       = 32;

endpackage

// File: rtl/branch_target_gen.sv
// Branch target: word offset from the sign-extended immediate, added to pc + 4.
module branch_target_gen
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc_plus4,
  input  logic [15:0]     imm16,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] offset;

  // Sign extension and the <<2 folded into one concatenation; the add wraps mod 2^32.
  assign offset = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign target = pc_plus4 + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetch/execute sequencing and next-pc selection.
//
// state | meaning
// RST   | one idle cycle after reset, all outputs idle
// FETCH | pc presented to instruction memory, waiting for imem_ready
// EXEC  | instruction at pc executing, controls sampled, next pc chosen
// HALT  | halt instruction executed, pc frozen until reset
// FAULT | misaligned jr target, pc frozen at the jr until reset
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jaddr26,
  input  logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4,
  output logic              fetch_req,
  output logic              instr_valid,
  output logic              fault,
  output logic              halted
);

  pc_state_t         state, state_nxt;
  logic [DATA_W-1:0] pc_nxt;
  logic [DATA_W-1:0] branch_target;
  logic [DATA_W-1:0] jump_target;

  assign pc_plus4    = pc + DATA_W'(WORD_BYTES);
  assign jump_target = {pc_plus4[DATA_W-1:DATA_W-4], jaddr26, 2'b00};

  branch_target_gen u_branch_target_gen (
    .pc_plus4 (pc_plus4),
    .imm16    (imm16),
    .target   (branch_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      RST:   state_nxt = FETCH;
      FETCH: if (imem_ready) state_nxt = EXEC;
      EXEC: begin
        // Stall outranks every other control; the if-chain below is the priority order.
        if (!stall) begin
          if (halt) begin
            state_nxt = HALT;
          end else if (jump_reg) begin
            if (rs_data[1:0] != 2'b00) begin
              state_nxt = FAULT;
            end else begin
              pc_nxt    = rs_data;
              state_nxt = FETCH;
            end
          end else if (jump) begin
            pc_nxt    = jump_target;
            state_nxt = FETCH;
          end else if (branch_taken) begin
            pc_nxt    = branch_target;
            state_nxt = FETCH;
          end else begin
            pc_nxt    = pc_plus4;
            state_nxt = FETCH;
          end
        end
      end
      HALT:    state_nxt = HALT;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RST;
    endcase
  end

  assign fetch_req   = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign fault       = (state == FAULT);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected pcs queued at issue, checked at next EXEC.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] jaddr26 = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_req;
  logic        instr_valid;
  logic        fault;
  logic        halted;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb_q[$];

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .imm16        (imm16),
    .jaddr26      (jaddr26),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_req    (fetch_req),
    .instr_valid  (instr_valid),
    .fault        (fault),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves the bench on a negedge where instr_valid is high, or reports a timeout.
  task automatic wait_exec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Drives one EXEC cycle worth of controls, then idles them.
  task automatic issue(input bit h, input bit jr, input bit j, input bit br,
                       input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] rs);
    halt = h; jump_reg = jr; jump = j; branch_taken = br;
    imm16 = imm; jaddr26 = ja; rs_data = rs;
    @(negedge clk);
    halt = 1'b0; jump_reg = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    imm16 = '0; jaddr26 = '0; rs_data = '0;
  endtask

  // Waits for the next EXEC and checks pc against the oldest queued expectation.
  task automatic check_next(input string name);
    bit          ok;
    logic [31:0] exp;
    wait_exec(ok);
    exp = sb_q.pop_front();
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: timeout waiting for EXEC, required pc %h", name, exp);
    end else if (pc !== exp) begin
      fails++;
      $display("FAIL %s: pc %h, required %h", name, pc, exp);
    end
  endtask

  task automatic test_reset();
    imem_ready = 1'b0;
    do_reset();
    tests++;
    if ({pc, fetch_req, instr_valid, fault, halted} !== {32'h0, 4'b0000}) begin
      fails++;
      $display("FAIL reset_state: pc %h fr %b iv %b f %b h %b, required 0 0 0 0 0",
               pc, fetch_req, instr_valid, fault, halted);
    end
    @(negedge clk);
    tests++;
    if (fetch_req !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_to_fetch: fetch_req %b instr_valid %b, required 1 0", fetch_req, instr_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic        exp_iv;
    imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back({31'(i / 2) << 2, 1'b0} >> 1);
      exp_iv = (i % 2) == 1;
      exp_pc = sb_q.pop_front();
      tests++;
      if (pc !== exp_pc || instr_valid !== exp_iv) begin
        fails++;
        $display("FAIL seq_%0d: pc %h iv %b, required pc %h iv %b", i, pc, instr_valid, exp_pc, exp_iv);
      end
      @(negedge clk);
    end
    // Now in FETCH at 0x10; starve memory, then reset mid-fetch.
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (fetch_req !== 1'b1 || pc !== 32'h10) begin
      fails++;
      $display("FAIL fetch_wait: fetch_req %b pc %h, required 1 00000010", fetch_req, pc);
    end
    do_reset();
    tests++;
    if (pc !== 32'h0 || fetch_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_fetch: pc %h fr %b iv %b, required 0 0 0", pc, fetch_req, instr_valid);
    end
  endtask

  task automatic goto_pc(input logic [31:0] target, input string name);
    bit ok;
    wait_exec(ok);
    issue(0, 1, 0, 0, 16'h0, 26'h0, target);
    sb_q.push_back(target);
    check_next(name);
  endtask

  task automatic test_branch();
    imem_ready = 1'b1;
    do_reset();
    goto_pc(32'h100, "jr_0x100");
    issue(0, 0, 0, 1, 16'h0003, 26'h0, 32'h0);
    sb_q.push_back(32'h110);
    check_next("branch_pos");
    goto_pc(32'h100, "jr_0x100_b");
    issue(0, 0, 0, 1, 16'hFFFF, 26'h0, 32'h0);
    sb_q.push_back(32'h100);
    check_next("branch_self_loop");
    issue(0, 0, 0, 1, 16'h8000, 26'h0, 32'h0);
    sb_q.push_back(32'hFFFE0104);
    check_next("branch_most_neg");
  endtask

  task automatic test_jump();
    goto_pc(32'h4000_0010, "jr_0x40000010");
    issue(0, 0, 1, 0, 16'h0, 26'h0000123, 32'h0);
    sb_q.push_back(32'h4000048C);
    check_next("jump");
    issue(0, 0, 1, 1, 16'h0003, 26'h0000040, 32'h0);
    sb_q.push_back(32'h40000100);
    check_next("jump_over_branch");
  endtask

  task automatic test_jr_fault();
    goto_pc(32'h2000, "jr_aligned");
    issue(0, 1, 0, 0, 16'h0, 26'h0, 32'h0000_2002);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (fault !== 1'b1 || pc !== 32'h2000 || instr_valid !== 1'b0 || fetch_req !== 1'b0) begin
        fails++;
        $display("FAIL jr_fault_%0d: fault %b pc %h iv %b fr %b, required 1 00002000 0 0",
                 i, fault, pc, instr_valid, fetch_req);
      end
      @(negedge clk);
    end
    do_reset();
    tests++;
    if (fault !== 1'b0 || pc !== 32'h0) begin
      fails++;
      $display("FAIL fault_clear: fault %b pc %h, required 0 00000000", fault, pc);
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] held;
    goto_pc(32'h300, "jr_0x300");
    wait_exec(ok);
    held = pc;
    stall = 1'b1; branch_taken = 1'b1; imm16 = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (pc !== held || instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_%0d: pc %h iv %b, required pc %h iv 1", i, pc, instr_valid, held);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    branch_taken = 1'b0; imm16 = '0;
    sb_q.push_back(32'h310);
    check_next("stall_release_branch");
  endtask

  task automatic test_wrap_halt();
    goto_pc(32'hFFFF_FFFC, "jr_top");
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    sb_q.push_back(32'h0);
    check_next("pc_wrap");
    issue(1, 0, 1, 1, 16'h0003, 26'h0000123, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (halted !== 1'b1 || pc !== 32'h0 || instr_valid !== 1'b0 || fetch_req !== 1'b0) begin
        fails++;
        $display("FAIL halt_%0d: halted %b pc %h iv %b fr %b, required 1 00000000 0 0",
                 i, halted, pc, instr_valid, fetch_req);
      end
      @(negedge clk);
    end
    do_reset();
    tests++;
    if (halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_clear: halted %b, required 0", halted);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_jr_fault();
    imem_ready = 1'b1;
    test_stall();
    test_wrap_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter for the MIPS core.
- Sequences fetch/execute through a small FSM with a handshake to instruction memory.
- Selects the next PC from four sources: sequential, branch (sign-extended immediate shifted left 2, added to PC+4), jump (26-bit pseudo-direct) and jump-register.
- Flags misaligned jump-register targets as a sticky fault.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset; must be word aligned.
- DATA_W, 32, PC and register data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_ready  in  1  instruction memory returns the word for the current pc this cycle.
- stall  in  1  hold in EXEC; do not advance pc.
- halt  in  1  executing instruction is a halt; enter HALT.
- branch_taken  in  1  executing branch resolved taken (branch & ALU zero).
- jump  in  1  executing instruction is j/jal.
- jump_reg  in  1  executing instruction is jr.
- imm16  in  16  branch offset field of the executing instruction.
- jaddr26  in  26  jump target field.
- rs_data  in  32  register operand for jr.
- pc  out  32  current program counter.
- pc_plus4  out  32  pc + 4, combinational from pc, for the jal link path.
- fetch_req  out  1  pc is valid for instruction fetch.
- instr_valid  out  1  the instruction at pc is being executed this cycle.
- fault  out  1  sticky misaligned jr target.
- halted  out  1  processor halted.

Behaviour:
- Reset values (takes effect on the clock edge with reset=1, overriding all else, including mid-FETCH): pc=RESET_VECTOR, state=RST, fetch_req=0, instr_valid=0, fault=0, halted=0.
- States: RST, FETCH, EXEC, HALT, FAULT.
- RST: go to FETCH next cycle unconditionally; all outputs at reset values.
- FETCH:
  - fetch_req=1.
  - imem_ready=0: stay; unbounded wait.
  - imem_ready=1: go to EXEC next cycle. The fetch-to-execute latency is 1 cycle after ready.
- EXEC:
  - instr_valid=1, fetch_req=0.
  - Control inputs are sampled only in EXEC and ignored in all other states.
  - stall=1: pc held, stay in EXEC; stall takes precedence over every other control.
  - Otherwise, first match wins:
    1. halt: pc unchanged, go to HALT.
    2. jump_reg: if rs_data[1:0]!=0, pc unchanged and go to FAULT; else pc=rs_data, go to FETCH.
    3. jump: pc={pc_plus4[31:28], jaddr26, 2'b00}, go to FETCH.
    4. branch_taken: pc=pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}), go to FETCH.
    5. default: pc=pc_plus4, go to FETCH.
  - Simultaneously asserted controls resolve by this priority, with no error.
- Arithmetic is modulo 2^32:
  - 32'hFFFFFFFC + 4 wraps to 0.
  - Branch add wraps silently.
  - imm16=16'hFFFF gives an offset of -4, so the target equals pc (tight loop).
  - imm16=16'h8000 gives an offset of -131072.
- HALT: halted=1, pc frozen, all outputs otherwise idle; exit only on reset.
- FAULT: fault=1, pc frozen at the faulting instruction's address; exit only on reset.
- Throughput: 2 cycles per instruction minimum (FETCH+EXEC) when imem_ready is already high.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [2:0] pc_state_t {RST, FETCH, EXEC, HALT, FAULT};
  - localparams WORD_BYTES=4 and PC_W=32.
- One combinational sub-module, branch_target_gen:
  - inputs pc_plus4[31:0], imm16[15:0].
  - output target[31:0] = pc_plus4 + (sign_extend(imm16) << 2).
  - Reuses the existing sign-extension and shift-by-2 behaviour.
- Jump-target concatenation and next-pc mux stay inline in pc_sequencer.

Test Plan:
- Reset then imem_ready=1 held, no controls: pc sequence 0x0, 0x4, 0x8, 0xC, with instr_valid high every second cycle. Assert reset during a FETCH with imem_ready=0: pc returns to 0x0 and state to RST on that edge.
- pc=0x100, branch_taken=1 with imm16=0x0003 gives pc=0x110; with imm16=0xFFFF gives pc=0x100; with imm16=0x8000 gives pc=0xFFFE0104.
- pc=0x40000010, jump=1, jaddr26=0x0000123: pc=0x4000048C. jump=1 and branch_taken=1 together: jump target wins.
- jump_reg=1, rs_data=0x00002000 gives pc=0x2000. With rs_data=0x00002002: fault=1, pc unchanged, stays frozen with imem_ready=1 for 10 cycles until reset.
- In EXEC, stall=1 for 3 cycles together with branch_taken=1: pc held, instr_valid=1 all 3 cycles. On the stall release cycle the branch is taken.
- pc=0xFFFFFFFC, no controls: next pc=0x00000000. halt=1 in EXEC: halted=1 and pc frozen until reset.
